// File: rtl/vec_regfile.sv
// Vector register file: lane-masked write port, two registered read ports, sequenced bulk clear
// and a flat snapshot bus. Define VREG_BYPASS_EN to forward same-cycle writes/clears to reads.
module vec_regfile #(
  parameter  int DATA_W    = 512,
  parameter  int NUM_REGS  = 4,
  localparam int ADDR_W    = $clog2(NUM_REGS),
  localparam int NUM_LANES = DATA_W / 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [NUM_LANES-1:0]       wr_mask,
  output logic                       wr_ready,
  input  logic                       rd_en0,
  input  logic                       rd_en1,
  input  logic [ADDR_W-1:0]          rd_addr0,
  input  logic [ADDR_W-1:0]          rd_addr1,
  output logic [DATA_W-1:0]          rd_data0,
  output logic [DATA_W-1:0]          rd_data1,
  output logic                       rd_valid0,
  output logic                       rd_valid1,
  input  logic                       clr_req,
  output logic                       busy,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat
);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_idx, w_clr_idx_nxt;
  logic [DATA_W-1:0]   r_regs     [NUM_REGS];
  logic [DATA_W-1:0]   w_regs_nxt [NUM_REGS];
  logic [DATA_W-1:0]   w_lane_bits;
  logic [DATA_W-1:0]   w_rd_src0, w_rd_src1;
  logic [DATA_W-1:0]   r_rd_data0, r_rd_data1;
  logic                r_rd_valid0, r_rd_valid1;
  logic                w_wr_fire;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(NUM_REGS);
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    case (r_state)
      S_IDLE: begin
        if (clr_req) begin
          w_state_nxt   = S_CLEAR;
          w_clr_idx_nxt = '0;
        end
      end
      S_CLEAR: begin
        if (r_clr_idx == ADDR_W'(NUM_REGS - 1)) begin
          w_state_nxt   = S_IDLE;
          w_clr_idx_nxt = '0;
        end else begin
          w_clr_idx_nxt = r_clr_idx + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  assign wr_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_CLEAR);
  assign w_wr_fire = wr_en && wr_ready && addr_ok(wr_addr);

  always_comb begin
    w_lane_bits = '0;
    for (int i = 0; i < NUM_LANES; i++) w_lane_bits[32*i +: 32] = {32{wr_mask[i]}};
  end

  // Post-edge contents of every register; also the forwarding source in bypass builds.
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      w_regs_nxt[k] = r_regs[k];
      if (busy && r_clr_idx == ADDR_W'(k))
        w_regs_nxt[k] = '0;
      else if (w_wr_fire && wr_addr == ADDR_W'(k))
        w_regs_nxt[k] = (r_regs[k] & ~w_lane_bits) | (wr_data & w_lane_bits);
    end
  end

  // NOTE: storage is reset because the snapshot bus must read all-zero straight after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= w_regs_nxt[k];
    end
  end

  always_comb begin
    w_rd_src0 = '0;
    w_rd_src1 = '0;
`ifdef VREG_BYPASS_EN
    if (addr_ok(rd_addr0)) w_rd_src0 = w_regs_nxt[rd_addr0];
    if (addr_ok(rd_addr1)) w_rd_src1 = w_regs_nxt[rd_addr1];
`else
    if (addr_ok(rd_addr0)) w_rd_src0 = r_regs[rd_addr0];
    if (addr_ok(rd_addr1)) w_rd_src1 = r_regs[rd_addr1];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data0  <= '0;
      r_rd_data1  <= '0;
      r_rd_valid0 <= 1'b0;
      r_rd_valid1 <= 1'b0;
    end else begin
      r_rd_valid0 <= rd_en0;
      r_rd_valid1 <= rd_en1;
      if (rd_en0) r_rd_data0 <= w_rd_src0;
      if (rd_en1) r_rd_data1 <= w_rd_src1;
    end
  end

  assign rd_data0  = r_rd_data0;
  assign rd_data1  = r_rd_data1;
  assign rd_valid0 = r_rd_valid0;
  assign rd_valid1 = r_rd_valid1;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs_flat[k*DATA_W +: DATA_W] = r_regs[k];
  end

endmodule

// File: tb/tb_vec_regfile.sv
// Directed bench for vec_regfile: default 512x4 instance, an 8-register instance for reset
// during clear, and a 64x3 instance for out-of-range addressing.
module tb_vec_regfile;

`ifdef VREG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Instance m: DATA_W=512, NUM_REGS=4
  logic         m_rst_n = 1'b0, m_wr_en = 1'b0, m_rd_en0 = 1'b0, m_rd_en1 = 1'b0, m_clr_req = 1'b0;
  logic [1:0]   m_wr_addr = '0, m_rd_addr0 = '0, m_rd_addr1 = '0;
  logic [511:0] m_wr_data = '0;
  logic [15:0]  m_wr_mask = '0;
  logic         m_wr_ready, m_rd_valid0, m_rd_valid1, m_busy;
  logic [511:0] m_rd_data0, m_rd_data1;
  logic [2047:0] m_flat;

  // Instance e: DATA_W=64, NUM_REGS=8
  logic         e_rst_n = 1'b0, e_wr_en = 1'b0, e_rd_en0 = 1'b0, e_rd_en1 = 1'b0, e_clr_req = 1'b0;
  logic [2:0]   e_wr_addr = '0, e_rd_addr0 = '0, e_rd_addr1 = '0;
  logic [63:0]  e_wr_data = '0;
  logic [1:0]   e_wr_mask = '0;
  logic         e_wr_ready, e_rd_valid0, e_rd_valid1, e_busy;
  logic [63:0]  e_rd_data0, e_rd_data1;
  logic [511:0] e_flat;

  // Instance o: DATA_W=64, NUM_REGS=3
  logic         o_rst_n = 1'b0, o_wr_en = 1'b0, o_rd_en0 = 1'b0, o_rd_en1 = 1'b0, o_clr_req = 1'b0;
  logic [1:0]   o_wr_addr = '0, o_rd_addr0 = '0, o_rd_addr1 = '0;
  logic [63:0]  o_wr_data = '0;
  logic [1:0]   o_wr_mask = '0;
  logic         o_wr_ready, o_rd_valid0, o_rd_valid1, o_busy;
  logic [63:0]  o_rd_data0, o_rd_data1;
  logic [191:0] o_flat;

  vec_regfile #(.DATA_W(512), .NUM_REGS(4)) u_m (
    .clk(clk), .rst_n(m_rst_n), .wr_en(m_wr_en), .wr_addr(m_wr_addr), .wr_data(m_wr_data),
    .wr_mask(m_wr_mask), .wr_ready(m_wr_ready), .rd_en0(m_rd_en0), .rd_en1(m_rd_en1),
    .rd_addr0(m_rd_addr0), .rd_addr1(m_rd_addr1), .rd_data0(m_rd_data0), .rd_data1(m_rd_data1),
    .rd_valid0(m_rd_valid0), .rd_valid1(m_rd_valid1), .clr_req(m_clr_req), .busy(m_busy),
    .regs_flat(m_flat)
  );

  vec_regfile #(.DATA_W(64), .NUM_REGS(8)) u_e (
    .clk(clk), .rst_n(e_rst_n), .wr_en(e_wr_en), .wr_addr(e_wr_addr), .wr_data(e_wr_data),
    .wr_mask(e_wr_mask), .wr_ready(e_wr_ready), .rd_en0(e_rd_en0), .rd_en1(e_rd_en1),
    .rd_addr0(e_rd_addr0), .rd_addr1(e_rd_addr1), .rd_data0(e_rd_data0), .rd_data1(e_rd_data1),
    .rd_valid0(e_rd_valid0), .rd_valid1(e_rd_valid1), .clr_req(e_clr_req), .busy(e_busy),
    .regs_flat(e_flat)
  );

  vec_regfile #(.DATA_W(64), .NUM_REGS(3)) u_o (
    .clk(clk), .rst_n(o_rst_n), .wr_en(o_wr_en), .wr_addr(o_wr_addr), .wr_data(o_wr_data),
    .wr_mask(o_wr_mask), .wr_ready(o_wr_ready), .rd_en0(o_rd_en0), .rd_en1(o_rd_en1),
    .rd_addr0(o_rd_addr0), .rd_addr1(o_rd_addr1), .rd_data0(o_rd_data0), .rd_data1(o_rd_data1),
    .rd_valid0(o_rd_valid0), .rd_valid1(o_rd_valid1), .clr_req(o_clr_req), .busy(o_busy),
    .regs_flat(o_flat)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [511:0] v [4];
    logic [511:0] exp_r2;
    logic [63:0]  ev [8];
    logic [511:0] exp_e;
    int           busy_cnt;

    // ---------------- reset state ----------------
    step(); step();
    check("rst_busy", 512'(m_busy), 512'(1'b0));
    check("rst_wr_ready", 512'(m_wr_ready), 512'(1'b1));
    check("rst_rd_valid0", 512'(m_rd_valid0), 512'(1'b0));
    check("rst_rd_data1", m_rd_data1, '0);
    for (int k = 0; k < 4; k++) check($sformatf("rst_flat_r%0d", k), m_flat[k*512 +: 512], '0);
    m_rst_n = 1'b1; e_rst_n = 1'b1; o_rst_n = 1'b1;
    step();

    // ---------------- reset then read ----------------
    m_rd_en0 = 1'b1; m_rd_addr0 = 2'd0; m_rd_en1 = 1'b1; m_rd_addr1 = 2'd3;
    step();
    m_rd_en0 = 1'b0; m_rd_en1 = 1'b0;
    check("rd_r0_valid", 512'(m_rd_valid0), 512'(1'b1));
    check("rd_r0_data", m_rd_data0, '0);
    check("rd_r3_valid", 512'(m_rd_valid1), 512'(1'b1));
    check("rd_r3_data", m_rd_data1, '0);
    step();
    check("rd_valid_pulse", 512'(m_rd_valid0), 512'(1'b0));

    // ---------------- masked write ----------------
    m_wr_en = 1'b1; m_wr_addr = 2'd2; m_wr_data = {16{32'hAAAAAAAA}}; m_wr_mask = 16'hFFFF;
    step();
    m_wr_data = {16{32'h55555555}}; m_wr_mask = 16'h0001;
    step();
    exp_r2 = {{15{32'hAAAAAAAA}}, 32'h55555555};
    check("mask_flat_r2", m_flat[2*512 +: 512], exp_r2);
    m_wr_data = '1; m_wr_mask = 16'h0000;
    step();
    m_wr_en = 1'b0;
    check("mask0_no_change", m_flat[2*512 +: 512], exp_r2);
    m_rd_en1 = 1'b1; m_rd_addr1 = 2'd2;
    step();
    m_rd_en1 = 1'b0;
    check("mask_rd_r2", m_rd_data1, exp_r2);
    step();
    check("rd_hold_data", m_rd_data1, exp_r2);

    // ---------------- bypass ----------------
    m_wr_en = 1'b1; m_wr_addr = 2'd1; m_wr_data = 512'hFFFF; m_wr_mask = 16'hFFFF;
    step();
    m_wr_data = 512'h1234; m_rd_en0 = 1'b1; m_rd_addr0 = 2'd1;
    step();
    m_wr_en = 1'b0;
    check("byp_full", m_rd_data0, BYP ? 512'h1234 : 512'hFFFF);
    step();
    check("byp_next_read", m_rd_data0, 512'h1234);
    m_wr_en = 1'b1; m_wr_data = '1; m_wr_mask = 16'h0002;
    step();
    m_wr_en = 1'b0; m_rd_en0 = 1'b0;
    check("byp_partial", m_rd_data0, BYP ? 512'hFFFFFFFF_00001234 : 512'h1234);
    check("partial_commit", m_flat[1*512 +: 512], 512'hFFFFFFFF_00001234);

    // ---------------- bulk clear ----------------
    for (int k = 0; k < 4; k++) begin
      v[k] = {16{32'(32'h11111111 * (k + 1))}};
      m_wr_en = 1'b1; m_wr_addr = 2'(k); m_wr_data = v[k]; m_wr_mask = 16'hFFFF;
      step();
    end
    m_wr_en = 1'b0;
    m_clr_req = 1'b1;
    step();                                   // edge N
    m_clr_req = 1'b0;
    check("clr_busy_n1", 512'(m_busy), 512'(1'b1));
    check("clr_wr_ready_n1", 512'(m_wr_ready), 512'(1'b0));
    check("clr_r0_not_yet", m_flat[0 +: 512], v[0]);
    m_rd_en0 = 1'b1; m_rd_addr0 = 2'd2; m_rd_en1 = 1'b1; m_rd_addr1 = 2'd0;
    step();                                   // edge N+1
    m_rd_en0 = 1'b0; m_rd_en1 = 1'b0;
    busy_cnt = 1;
    check("clr_r0_zero", m_flat[0 +: 512], '0);
    check("clr_r1_kept", m_flat[512 +: 512], v[1]);
    check("clr_rd_other", m_rd_data0, v[2]);
    check("clr_rd_same", m_rd_data1, BYP ? 512'h0 : v[0]);
    if (m_busy) busy_cnt++;
    m_wr_en = 1'b1; m_wr_addr = 2'd0; m_wr_data = '1; m_wr_mask = 16'hFFFF; m_clr_req = 1'b1;
    step();                                   // edge N+2
    m_wr_en = 1'b0; m_clr_req = 1'b0;
    check("clr_r1_zero", m_flat[512 +: 512], '0);
    check("clr_wr_dropped", m_flat[0 +: 512], '0);
    if (m_busy) busy_cnt++;
    step();                                   // edge N+3
    check("clr_r2_zero", m_flat[1024 +: 512], '0);
    check("clr_r3_kept", m_flat[1536 +: 512], v[3]);
    if (m_busy) busy_cnt++;
    step();                                   // edge N+4
    check("clr_r3_zero", m_flat[1536 +: 512], '0);
    check("clr_done_ready", 512'(m_wr_ready), 512'(1'b1));
    if (m_busy) busy_cnt++;
    step();
    if (m_busy) busy_cnt++;
    check("clr_busy_cycles", 512'(busy_cnt), 512'(4));

    // ---------------- reset mid-clear (NUM_REGS=8) ----------------
    for (int k = 0; k < 8; k++) begin
      ev[k] = {2{32'(32'hA0A00000 + k)}};
      e_wr_en = 1'b1; e_wr_addr = 3'(k); e_wr_data = ev[k]; e_wr_mask = 2'b11;
      step();
    end
    e_wr_en = 1'b0;
    e_clr_req = 1'b1;
    step();
    e_clr_req = 1'b0;
    step(); step(); step();
    check("e_r2_zero", 512'(e_flat[2*64 +: 64]), '0);
    check("e_r3_kept", 512'(e_flat[3*64 +: 64]), 512'(ev[3]));
    e_rst_n = 1'b0;
    #1;
    check("e_rst_busy", 512'(e_busy), 512'(1'b0));
    check("e_rst_ready", 512'(e_wr_ready), 512'(1'b1));
    check("e_rst_flat", e_flat, '0);
    step();
    e_rst_n = 1'b1;
    step();
    e_wr_en = 1'b1; e_wr_addr = 3'd5; e_wr_data = 64'hDEADBEEF_CAFEF00D; e_wr_mask = 2'b11;
    step();
    e_wr_en = 1'b0;
    exp_e = '0;
    exp_e[5*64 +: 64] = 64'hDEADBEEF_CAFEF00D;
    check("e_wr_after_rst", e_flat, exp_e);

    // ---------------- DATA_W=64, NUM_REGS=3 ----------------
    o_wr_en = 1'b1; o_wr_mask = 2'b11;
    o_wr_addr = 2'd0; o_wr_data = 64'h01234567_89ABCDEF; step();
    o_wr_addr = 2'd2; o_wr_data = 64'hFEDCBA98_76543210; step();
    o_wr_addr = 2'd3; o_wr_data = 64'hFFFFFFFF_FFFFFFFF; step();
    o_wr_en = 1'b0;
    check("o_oob_wr_dropped", 512'(o_flat),
          512'({64'hFEDCBA98_76543210, 64'h0, 64'h01234567_89ABCDEF}));
    o_rd_en0 = 1'b1; o_rd_addr0 = 2'd2; o_rd_en1 = 1'b1; o_rd_addr1 = 2'd0;
    step();
    check("o_dual_r2", 512'(o_rd_data0), 512'(64'hFEDCBA98_76543210));
    check("o_dual_r0", 512'(o_rd_data1), 512'(64'h01234567_89ABCDEF));
    o_rd_addr0 = 2'd3; o_rd_en1 = 1'b0;
    step();
    o_rd_en0 = 1'b0;
    check("o_oob_rd_zero", 512'(o_rd_data0), '0);
    check("o_oob_rd_valid", 512'(o_rd_valid0), 512'(1'b1));
    check("o_p1_idle_valid", 512'(o_rd_valid1), 512'(1'b0));
    check("o_p1_hold", 512'(o_rd_data1), 512'(64'h01234567_89ABCDEF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
